// File: rtl/alu_pkg.sv
// Shared definitions for the ALU requester: opcode values, the legal-mode
// bound and the requester state encoding.
package alu_pkg;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] AND = 4'd2;
  localparam logic [3:0] OR  = 4'd3;
  localparam logic [3:0] XOR = 4'd4;
  localparam logic [3:0] EQ  = 4'd5;
  localparam logic [3:0] GE  = 4'd6;
  localparam logic [3:0] SRL = 4'd7;
  localparam logic [3:0] SLL = 4'd8;
  localparam logic [3:0] MUL = 4'd9;
  localparam logic [3:0] DIV = 4'd10;

  localparam logic [3:0] MODE_MAX = DIV;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ERR,
    HOLD
  } state_e;

  function automatic logic mode_legal(input logic [3:0] mode);
    return mode <= MODE_MAX;
  endfunction

endpackage

// File: rtl/alu_requester.sv
// Single-outstanding ALU requester: accepts a command, fires a one-cycle ALU
// request, waits (bounded) for the response pulse and holds the result until drained.
module alu_requester
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_A,
  input  logic [31:0] cmd_B,
  input  logic [3:0]  cmd_mode,
  output logic        alu_valid,
  output logic [31:0] alu_in_A,
  output logic [31:0] alu_in_B,
  output logic [3:0]  alu_mode,
  input  logic        alu_ready,
  input  logic [63:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [3:0]  res_mode,
  output logic        res_err,
  output logic [15:0] ops_done
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [3:0]    mode_q, mode_d;
  logic [63:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [15:0]   ops_q, ops_d;

  // NOTE: every register, datapath included, is reset so that a reset mid-WAIT
  // or mid-HOLD leaves no trace of the dropped operation on any output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so all registers update from the
      // same pre-edge values regardless of statement order.
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ops_q   <= ops_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no
    // branch of the case below can leave a latch behind.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    data_d  = data_q;
    err_d   = err_q;
    ops_d   = ops_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_d     = cmd_A;
          b_d     = cmd_B;
          mode_d  = cmd_mode;
          state_d = mode_legal(cmd_mode) ? ISSUE : ERR;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q + CW'(1);
        // A response arriving on the timeout cycle still wins.
        if (alu_ready) begin
          data_d  = alu_out;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (wcnt_q == WAIT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = HOLD;
        end
      end
      ERR: begin
        data_d  = '0;
        err_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          ops_d   = ops_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst keeps cmd_ready low while reset is held.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign alu_valid = (state_q == ISSUE);
  assign alu_in_A  = a_q;
  assign alu_in_B  = b_q;
  assign alu_mode  = mode_q;
  assign res_valid = (state_q == HOLD);
  assign res_data  = data_q;
  assign res_mode  = mode_q;
  assign res_err   = err_q;
  assign ops_done  = ops_q;

endmodule

// File: doc/alu_requester.md
ALU_REQUESTER -- requirements
Module: alu_requester

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, the maximum number of cycles to wait for alu_ready before aborting.
REQ-002 SHALL have port clk, input, 1 bit, the single clock.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_A (in, 32), cmd_B (in, 32), cmd_mode (in, 4); together these form the upstream command handshake.
REQ-005 SHALL have ports alu_valid (out, 1), alu_in_A (out, 32), alu_in_B (out, 32), alu_mode (out, 4); these are the request to the ALU.
REQ-006 SHALL have ports alu_ready (in, 1) and alu_out (in, 64); these are the ALU response, with alu_ready a one-cycle pulse.
REQ-007 SHALL have ports res_valid (out, 1), res_ready (in, 1), res_data (out, 64), res_mode (out, 4), res_err (out, 1); together these form the downstream result handshake.
REQ-008 SHALL have port ops_done, output, 16 bits, a count of completed results.

Function
REQ-009 SHALL implement a state machine with states IDLE, ISSUE, WAIT, ERR and HOLD.
REQ-010 SHALL assert cmd_ready only when the state is IDLE; the command transfers on cmd_valid && cmd_ready.
REQ-011 SHALL latch cmd_A, cmd_B and cmd_mode on acceptance; the latched values drive alu_in_A, alu_in_B and alu_mode, held stable until the next acceptance.
REQ-012 SHALL, on acceptance of a legal mode (0-10), enter ISSUE; on acceptance of an illegal mode (11-15), enter ERR without ever asserting alu_valid.
REQ-013 SHALL assert alu_valid for exactly one cycle, in ISSUE, then go to WAIT; alu_valid SHALL never be held longer, because the ALU relaunches on a held valid.
REQ-014 SHALL, in WAIT, increment a wait counter every cycle.
REQ-015 SHALL, when alu_ready=1 in WAIT, capture alu_out into res_data with res_err=0 and go to HOLD.
REQ-016 SHALL, when the wait counter reaches TIMEOUT-1 without alu_ready, load res_data=0 and res_err=1 and go to HOLD.
REQ-017 SHALL, when alu_ready and the timeout occur in the same cycle, take the alu_ready path.
REQ-018 SHALL, in ERR, load res_data=0 and res_err=1 and go to HOLD; ERR lasts one cycle.
REQ-019 SHALL assert res_valid only in HOLD, with res_mode equal to the latched mode; on res_valid && res_ready it SHALL return to IDLE.
REQ-020 SHALL hold res_data, res_mode and res_err stable while res_valid=1 and res_ready=0.
REQ-021 SHALL ignore alu_ready in any state other than WAIT (stray or late pulses).
REQ-022 SHALL have a best-case latency of accept(N) -> alu_valid(N+1); ALU pulse at cycle M -> res_valid(M+1).
REQ-023 SHALL have a latency of accept(N) -> res_valid(N+2) for an illegal mode.
REQ-024 SHALL increment ops_done on every result transfer, errors included, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL have at most one operation outstanding at any time.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, set state=IDLE and the wait counter to 0.
REQ-027 SHALL, on reset, clear alu_valid, res_valid, res_err, res_data, res_mode, alu_in_A, alu_in_B, alu_mode and ops_done to 0; cmd_ready SHALL become 1 on the first cycle after reset release.
REQ-028 SHALL, on reset mid-WAIT or mid-HOLD, drop the pending operation and result silently, and ignore any later alu_ready.

Structure
REQ-029 SHALL take the following from the shared package alu_pkg:
- mode constants ADD=0, SUB=1, AND=2, OR=3, XOR=4, EQ=5, GE=6, SRL=7, SLL=8, MUL=9, DIV=10;
- MODE_MAX=10;
- the state enum type.
REQ-030 SHALL have no sub-module; it is a single flat module, and the wait counter width is $clog2(TIMEOUT)+1.

Verification
REQ-031 SHALL be covered by a scenario: ADD, A=5, B=3, with an ALU model pulsing ready 1 cycle after valid -> res_data=8, res_err=0, res_mode=0, alu_valid high exactly 1 cycle.
REQ-032 SHALL be covered by a scenario: MUL, A=3, B=4, with the ALU model responding after 33 cycles -> res_data=12, no timeout, ops_done increments by 1.
REQ-033 SHALL be covered by a scenario: mode=4'b1100 -> alu_valid never asserts, res_valid 2 cycles after accept, res_err=1, res_data=0.
REQ-034 SHALL be covered by a scenario: ALU model never responds -> res_err=1 after TIMEOUT cycles in WAIT; an alu_ready pulse injected afterwards is ignored.
REQ-035 SHALL be covered by a scenario: res_ready held low for 10 cycles -> res_* stable, cmd_ready=0 throughout, a second command is accepted only after the drain.
REQ-036 SHALL be covered by a scenario: rst asserted mid-WAIT -> all outputs 0 the next cycle, ops_done=0, a subsequent ADD completes normally.
